// File: rtl/pair_sum_fifo_pkg.sv
// pair_sum_fifo_pkg: default sizes and {a,b,sum} entry layout for the pair-sum FIFO
package pair_sum_fifo_pkg;
  localparam int PAIR_W     = 5;
  localparam int PAIR_DEPTH = 4;
  localparam int PAIR_AW    = 2;
  localparam int SUM_LSB    = 0;
  localparam int B_LSB      = PAIR_W + 1;
  localparam int A_LSB      = 2 * PAIR_W + 1;
  localparam int ENTRY_W    = 3 * PAIR_W + 1;
  function automatic int b_lsb(input int w);
    return w + 1;
  endfunction
  function automatic int a_lsb(input int w);
    return 2 * w + 1;
  endfunction
  function automatic int entry_w(input int w);
    return 3 * w + 1;
  endfunction
endpackage

// File: rtl/pair_fifo_mem.sv
// pair_fifo_mem: DEPTH x EW register array, synchronous write, asynchronous read, no reset
module pair_fifo_mem #(
  parameter int DEPTH = 4,
  parameter int AW    = 2,
  parameter int EW    = 16
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [EW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [EW-1:0] rdata
);
  logic [EW-1:0] mem_q [DEPTH];
  // write the entry selected by the write pointer
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end
  assign rdata = mem_q[raddr];
endmodule

// File: rtl/pair_sum_fifo.sv
// pair_sum_fifo: show-ahead FIFO of {a,b,a+b}; PAIR_STATS_EN adds stat_cnt/stat_max ports
module pair_sum_fifo
  import pair_sum_fifo_pkg::*;
#(
  parameter int W     = PAIR_W,
  parameter int DEPTH = PAIR_DEPTH,
  parameter int AW    = PAIR_AW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_a,
  input  logic [W-1:0]  in_b,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_a,
  output logic [W-1:0]  out_b,
  output logic [W:0]    out_sum,
`ifdef PAIR_STATS_EN
  output logic [15:0]   stat_cnt,
  output logic [W:0]    stat_max,
`endif
  output logic [AW:0]   count
);
  localparam int EW = entry_w(W);
  localparam int BL = b_lsb(W);
  localparam int AL = a_lsb(W);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          full, empty, push, pop;
  logic [W:0]    sum;
  logic [EW-1:0] wdata, rdata;
  pair_fifo_mem #(.DEPTH(DEPTH), .AW(AW), .EW(EW)) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr_q),
    .wdata (wdata),
    .raddr (rd_ptr_q),
    .rdata (rdata)
  );
  // handshakes, pointer/count next state and zero-gated head outputs
  always_comb begin
    full      = count_q == FULL_CNT;
    empty     = count_q == '0;
    in_ready  = !full;
    out_valid = !empty;
    push      = in_valid && !full;
    pop       = out_ready && !empty;
    sum       = (W+1)'(in_a) + (W+1)'(in_b);
    wdata     = {in_a, in_b, sum};
    wr_ptr_d  = wr_ptr_q + AW'(push);
    rd_ptr_d  = rd_ptr_q + AW'(pop);
    count_d   = (push && !pop) ? count_q + 1'b1 : (pop && !push) ? count_q - 1'b1 : count_q;
    out_a     = empty ? '0 : rdata[AL +: W];
    out_b     = empty ? '0 : rdata[BL +: W];
    out_sum   = empty ? '0 : rdata[0 +: W+1];
    count     = count_q;
  end
  // pointer and occupancy registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end
`ifdef PAIR_STATS_EN
  logic [15:0] stat_cnt_q, stat_cnt_d;
  logic [W:0]  stat_max_q, stat_max_d;
  // saturating push counter and running maximum of pushed sums
  always_comb begin
    stat_cnt_d = (push && stat_cnt_q != 16'hFFFF) ? stat_cnt_q + 16'd1 : stat_cnt_q;
    stat_max_d = (push && sum > stat_max_q) ? sum : stat_max_q;
    stat_cnt   = stat_cnt_q;
    stat_max   = stat_max_q;
  end
  // statistics registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_cnt_q <= '0;
      stat_max_q <= '0;
    end else begin
      stat_cnt_q <= stat_cnt_d;
      stat_max_q <= stat_max_d;
    end
  end
`endif
endmodule

// File: tb/tb_pair_sum_fifo.sv
// tb_pair_sum_fifo: directed and random checks of pair_sum_fifo against a queue model
module tb_pair_sum_fifo;
  logic       clk = 0, rst_n = 0;
  logic       in_valid = 0, in_ready, out_valid, out_ready = 0;
  logic [4:0] in_a = 0, in_b = 0, out_a, out_b;
  logic [5:0] out_sum;
  logic [2:0] count;
`ifdef PAIR_STATS_EN
  logic [15:0] stat_cnt;
  logic [5:0]  stat_max;
`endif
  typedef struct {int a; int b;} pair_t;
  pair_t q[$];
  int m_cnt = 0, m_max = 0;
  int n_tests = 0, n_fail = 0;

  pair_sum_fifo dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready),
    .out_a(out_a), .out_b(out_b), .out_sum(out_sum),
`ifdef PAIR_STATS_EN
    .stat_cnt(stat_cnt), .stat_max(stat_max),
`endif
    .count(count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_state();
    check("in_ready", in_ready, q.size() < 4);
    check("out_valid", out_valid, q.size() > 0);
    check("count", count, q.size());
    check("out_a", out_a, q.size() ? q[0].a : 0);
    check("out_b", out_b, q.size() ? q[0].b : 0);
    check("out_sum", out_sum, q.size() ? q[0].a + q[0].b : 0);
`ifdef PAIR_STATS_EN
    check("stat_cnt", stat_cnt, m_cnt);
    check("stat_max", stat_max, m_max);
`endif
  endtask

  task automatic cyc(input logic v, input int a, input int b, input logic r);
    bit push, pop;
    in_valid = v; in_a = 5'(a); in_b = 5'(b); out_ready = r;
    #1;
    check_state();
    push = v && q.size() < 4;
    pop  = r && q.size() > 0;
    @(posedge clk); #1;
    if (pop) void'(q.pop_front());
    if (push) begin
      q.push_back('{a, b});
      if (m_cnt < 65535) m_cnt++;
      if (a + b > m_max) m_max = a + b;
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_count", count, 0);
    check("rst_out_sum", out_sum, 0);
    @(negedge clk) rst_n = 1;
    @(posedge clk); #1;
    cyc(1, 10, 20, 0);
    cyc(0, 0, 0, 0);
    check("single_sum", out_sum, 30);
    cyc(0, 0, 0, 1);
    for (int i = 0; i < 4; i++) cyc(1, 10 + i, 20 + i, 0);
    cyc(1, 14, 24, 0);
    check("fill_count", count, 4);
    check("fill_ready", in_ready, 0);
    cyc(1, 14, 24, 1);
    check("full_pop_count", count, 3);
    cyc(1, 14, 24, 0);
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 1);
    cyc(1, 31, 31, 0);
    check("sum62", out_sum, 62);
    cyc(1, 31, 0, 1);
    check("sum31", out_sum, 31);
    cyc(0, 0, 0, 1);
    for (int i = 0; i < 300; i++)
      cyc($urandom_range(0, 3) != 0, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 1) == 1);
    while (q.size() > 3) cyc(0, 0, 0, 1);
    while (q.size() < 3) cyc(1, $urandom_range(0, 31), $urandom_range(0, 31), 0);
    check("pre_reset_count", count, 3);
    in_valid = 1; out_ready = 1;
    #2 rst_n = 0;
    #1;
    check("mid_rst_count", count, 0);
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_sum", out_sum, 0);
`ifdef PAIR_STATS_EN
    check("mid_rst_stat_cnt", stat_cnt, 0);
    check("mid_rst_stat_max", stat_max, 0);
`endif
    q.delete(); m_cnt = 0; m_max = 0;
    in_valid = 0; out_ready = 0;
    @(negedge clk) rst_n = 1;
    @(posedge clk); #1;
    for (int i = 0; i < 100; i++)
      cyc($urandom_range(0, 1) == 1, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 2) == 0);
    cyc(0, 0, 0, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
